tx_stream_arbiter: RTL and testbench
====================================

TX_STREAM_ARBITER -- requirements
Module: tx_stream_arbiter

Interface
REQ-001 SHALL have parameter LEN_BITS, default 8: width of the payload-length field in a header word (bits [LEN_BITS-1:0]).
REQ-002 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-004 SHALL have ports input_0, input_1, input_2, input, 32 each: requester data words.
REQ-005 SHALL have ports input_0_stb, input_1_stb, input_2_stb, input, 1 each: requester word valid.
REQ-006 SHALL have ports input_0_ack, input_1_ack, input_2_ack, output, 1 each: word accepted from that requester.
REQ-007 SHALL have port output_tx, output, 32: shared stream data, e.g. to rs232_tx or eth_tx.
REQ-008 SHALL have port output_tx_stb, output, 1: output word valid.
REQ-009 SHALL have port output_tx_ack, input, 1: sink accepted output word.
REQ-010 SHALL have port grant, output, 2: index of the owning requester; 3 when idle.
REQ-011 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-012 SHALL transfer a word on any stb/ack pair only in a cycle where both are high at the clock edge.
REQ-013 SHALL treat each packet as one header word followed by N = header[LEN_BITS-1:0] payload words; N=0 means header only.
REQ-014 SHALL implement states IDLE, LOAD and SEND.
REQ-015 In IDLE, when any input_k_stb is high, SHALL select g = the first requester with stb high, scanning from (last+1) mod 3 upward; then register grant=g and go to LOAD.
REQ-016 In IDLE with no stb high, SHALL remain in IDLE with all input_k_ack low.
REQ-017 In LOAD, input_g_ack SHALL equal input_g_stb combinationally; every other input_k_ack SHALL be 0.
REQ-018 On a LOAD transfer, SHALL register output_tx <= input_g, set output_tx_stb <= 1 and go to SEND.
REQ-019 On a LOAD transfer of a header, SHALL load remaining <= header[LEN_BITS-1:0].
REQ-020 In LOAD with input_g_stb low, SHALL wait indefinitely; the grant is never revoked mid-packet.
REQ-021 In SEND, SHALL hold output_tx and output_tx_stb stable until output_tx_ack is high.
REQ-022 On a SEND transfer with remaining=0, SHALL clear output_tx_stb, set last <= g and go to IDLE.
REQ-023 On a SEND transfer with remaining>0, SHALL decrement remaining, clear output_tx_stb and go to LOAD.
REQ-024 SHALL assert no input_k_ack in SEND or IDLE, so no requester is acked while an output word is pending.
REQ-025 Latency: with the sink acking immediately, output_tx_stb SHALL rise 2 cycles after input_g_stb is first sampled high in IDLE.
REQ-026 Throughput: SHALL sustain at most 1 word per 2 cycles; a packet of N payload words SHALL take at least 2(N+1) cycles plus 1 IDLE cycle.
REQ-027 Requests arriving while busy SHALL wait; arbitration SHALL occur only at packet boundaries in IDLE.
REQ-028 Round-robin: with all three stb held high, successive packets SHALL be granted 0,1,2,0,...
REQ-029 When the remaining counter reaches 0 it SHALL NOT wrap; header value 2^LEN_BITS-1 SHALL yield exactly that many payload words.
REQ-030 output_tx_ack high while output_tx_stb is low SHALL be ignored.

Reset
REQ-031 On rst high at a clock edge, SHALL set state=IDLE, output_tx_stb=0, output_tx=0, grant=3, busy=0, remaining=0 and last=2, so requester 0 has first priority.
REQ-032 All input_k_ack SHALL be 0 while rst is high.
REQ-033 Reset mid-packet SHALL abandon the packet with no further output words; the requester must restart from a header.

Verification
REQ-034 Only input_1 sends header 0x00000002 then 0xA, 0xB with output_tx_ack held 1 -> output_tx carries 0x2, 0xA, 0xB; grant=1 during the packet; then grant=3 and busy=0.
REQ-035 All three inputs offer header 0x0 continuously after reset -> grants go 0,1,2,0; each packet is 1 word; input_k_ack is never high for a non-granted k.
REQ-036 Hold output_tx_ack=0 for 10 cycles mid-packet -> output_tx and output_tx_stb stay stable; no input ack occurs; the packet completes after ack.
REQ-037 input_2 drops stb for 5 cycles after its header (N=3) while input_0 requests -> grant stays 2 until all 3 payload words pass, then moves to 0.
REQ-038 Assert rst in SEND of a 4-word packet -> the next cycle shows output_tx_stb=0, grant=3, acks=0, and the next grant goes to requester 0.
REQ-039 Header 0x000000FF (LEN_BITS=8) -> exactly 255 payload words are forwarded and the state returns to IDLE.

Source files
------------

// File: rtl/tx_stream_arbiter.sv
// rtl/tx_stream_arbiter.sv - three-way round-robin packet arbiter onto one output word stream
module tx_stream_arbiter #(
  parameter int LEN_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_0,
  input  logic [31:0] input_1,
  input  logic [31:0] input_2,
  input  logic        input_0_stb,
  input  logic        input_1_stb,
  input  logic        input_2_stb,
  output logic        input_0_ack,
  output logic        input_1_ack,
  output logic        input_2_ack,
  output logic [31:0] output_tx,
  output logic        output_tx_stb,
  input  logic        output_tx_ack,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          last_q, last_d;
  logic [LEN_BITS-1:0] remaining_q, remaining_d;
  logic                header_q, header_d;
  logic [31:0]         tx_q, tx_d;
  logic                tx_stb_q, tx_stb_d;
  logic                busy_q, busy_d;

  logic [2:0]  stb_v;
  logic [2:0]  grant_oh;
  logic [2:0]  ack_v;
  logic [31:0] sel_data;
  logic        sel_stb;
  logic [1:0]  rr_pick;

  assign stb_v = {input_2_stb, input_1_stb, input_0_stb};

  // Scan starts one past the previous owner so every requester gets a turn.
  always_comb begin
    rr_pick = 2'd3;
    case (last_q)
      2'd0: begin
        if (stb_v[1])      rr_pick = 2'd1;
        else if (stb_v[2]) rr_pick = 2'd2;
        else if (stb_v[0]) rr_pick = 2'd0;
      end
      2'd1: begin
        if (stb_v[2])      rr_pick = 2'd2;
        else if (stb_v[0]) rr_pick = 2'd0;
        else if (stb_v[1]) rr_pick = 2'd1;
      end
      default: begin
        if (stb_v[0])      rr_pick = 2'd0;
        else if (stb_v[1]) rr_pick = 2'd1;
        else if (stb_v[2]) rr_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    grant_oh = 3'b000;
    sel_data = input_0;
    case (grant_q)
      2'd0: begin grant_oh = 3'b001; sel_data = input_0; end
      2'd1: begin grant_oh = 3'b010; sel_data = input_1; end
      2'd2: begin grant_oh = 3'b100; sel_data = input_2; end
      default: ;
    endcase
    sel_stb = |(stb_v & grant_oh);
  end

  // Only the owner is ever acked, and only while no output word is pending.
  always_comb begin
    ack_v = 3'b000;
    if (!rst && state_q == LOAD) ack_v = stb_v & grant_oh;
  end

  assign input_0_ack = ack_v[0];
  assign input_1_ack = ack_v[1];
  assign input_2_ack = ack_v[2];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    remaining_d = remaining_q;
    header_d    = header_q;
    tx_d        = tx_q;
    tx_stb_d    = tx_stb_q;
    case (state_q)
      IDLE: begin
        if (|stb_v) begin
          grant_d  = rr_pick;
          header_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (sel_stb) begin
          tx_d     = sel_data;
          tx_stb_d = 1'b1;
          header_d = 1'b0;
          if (header_q) remaining_d = sel_data[LEN_BITS-1:0];
          state_d  = SEND;
        end
      end
      SEND: begin
        if (output_tx_ack) begin
          tx_stb_d = 1'b0;
          if (remaining_q == '0) begin
            last_d  = grant_q;
            grant_d = 2'd3;
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - 1'b1;
            state_d     = LOAD;
          end
        end
      end
      default: begin
        grant_d  = 2'd3;
        tx_stb_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'd3;
      last_q      <= 2'd2;
      remaining_q <= '0;
      header_q    <= 1'b0;
      tx_q        <= '0;
      tx_stb_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      remaining_q <= remaining_d;
      header_q    <= header_d;
      tx_q        <= tx_d;
      tx_stb_q    <= tx_stb_d;
      busy_q      <= busy_d;
    end
  end

  assign output_tx     = tx_q;
  assign output_tx_stb = tx_stb_q;
  assign grant         = grant_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// tb/tb_tx_stream_arbiter.sv - randomized bench for tx_stream_arbiter against a packet-level model
module tb_tx_stream_arbiter;

  localparam int LEN_BITS = 8;

  typedef logic [31:0] word_q_t [$];
  typedef struct {
    logic [31:0] word;
    int          owner;
    bit          last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data [3];
  logic [2:0]  in_stb = 3'b000;
  logic        a0, a1, a2;
  logic [2:0]  in_ack;
  logic [31:0] output_tx;
  logic        output_tx_stb;
  logic        output_tx_ack = 1'b0;
  logic [1:0]  grant;
  logic        busy;

  assign in_ack = {a2, a1, a0};

  always #5 clk = ~clk;

  tx_stream_arbiter #(.LEN_BITS(LEN_BITS)) dut (
    .clk           (clk),
    .rst           (rst),
    .input_0       (in_data[0]),
    .input_1       (in_data[1]),
    .input_2       (in_data[2]),
    .input_0_stb   (in_stb[0]),
    .input_1_stb   (in_stb[1]),
    .input_2_stb   (in_stb[2]),
    .input_0_ack   (a0),
    .input_1_ack   (a1),
    .input_2_ack   (a2),
    .output_tx     (output_tx),
    .output_tx_stb (output_tx_stb),
    .output_tx_ack (output_tx_ack),
    .grant         (grant),
    .busy          (busy)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  word_q_t     req_q [3];
  exp_t        exp_q [$];
  logic [31:0] out_log [$];
  int          grant_log [$];
  int          in_owner = -1;
  int          in_rem   = 0;
  int          last_m   = 2;
  int          stb_pct  = 100;
  int          ack_pct  = 100;
  bit          drop_en  = 1'b0;
  int          drop_cnt [3];
  bit          have_snap = 1'b0;

  logic [2:0]  s_ack, s_stb;
  logic [31:0] s_data [3];
  logic        s_out_stb, s_out_ack;
  logic [31:0] s_out_tx;
  logic [1:0]  s_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [2:0] s);
    for (int i = 1; i <= 3; i++) begin
      int k;
      k = (last + i) % 3;
      if (s[k]) return k;
    end
    return 3;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      req_q[k].delete();
      drop_cnt[k] = 0;
    end
    exp_q.delete();
    in_owner  = -1;
    in_rem    = 0;
    last_m    = 2;
    have_snap = 1'b0;
  endtask

  task automatic push_packet(input int k, input int n);
    logic [31:0] h;
    h = $urandom;
    h[LEN_BITS-1:0] = n[LEN_BITS-1:0];
    req_q[k].push_back(h);
    for (int i = 0; i < n; i++) req_q[k].push_back($urandom);
  endtask

  task automatic model_accept(input int k, input logic [31:0] w);
    exp_t e;
    bit   hdr;
    void'(req_q[k].pop_front());
    hdr = (in_owner < 0);
    if (hdr) begin
      in_owner = k;
      in_rem   = int'(w[LEN_BITS-1:0]);
    end else begin
      check_eq("pkt_owner", k, in_owner);
      in_rem--;
    end
    e.word  = w;
    e.owner = k;
    e.last  = (in_rem == 0);
    exp_q.push_back(e);
    if (e.last) in_owner = -1;
    if (drop_en && hdr && k == 2) drop_cnt[2] = 5;
  endtask

  task automatic model_emit();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("out_extra", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    out_log.push_back(s_out_tx);
    check_eq("out_word", s_out_tx, e.word);
    check_eq("out_grant", s_grant, e.owner);
    check_eq("post_send_stb", output_tx_stb, 0);
    if (e.last) begin
      last_m = e.owner;
      check_eq("pkt_end_grant", grant, 3);
    end else begin
      check_eq("mid_pkt_grant", grant, e.owner);
    end
  endtask

  // Judge the clock edge that just passed using what was visible just before it.
  task automatic process();
    logic [2:0] oh, exp_ack;
    bit         load;
    oh      = (s_grant == 2'd3) ? 3'b000 : (3'b001 << s_grant);
    load    = (s_grant != 2'd3) && !s_out_stb;
    exp_ack = load ? (s_stb & oh) : 3'b000;
    check_eq("ack_vec", s_ack, exp_ack);
    check_eq("busy", busy, grant != 2'd3);
    if (s_grant == 2'd3) begin
      int g;
      g = (s_stb != 3'b000) ? rr(last_m, s_stb) : 3;
      check_eq("arb_grant", grant, g);
      if (g != 3) grant_log.push_back(g);
    end else if (load) begin
      if (s_stb[s_grant]) begin
        model_accept(int'(s_grant), s_data[s_grant]);
        check_eq("load_stb", output_tx_stb, 1);
        check_eq("load_tx", output_tx, s_data[s_grant]);
      end else begin
        check_eq("load_wait_grant", grant, s_grant);
        check_eq("load_wait_stb", output_tx_stb, 0);
      end
    end else if (s_out_ack) begin
      model_emit();
    end else begin
      check_eq("stall_stb", output_tx_stb, 1);
      check_eq("stall_tx", output_tx, s_out_tx);
      check_eq("stall_grant", grant, s_grant);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (have_snap) process();
    for (int k = 0; k < 3; k++) begin
      if (req_q[k].size() > 0 && drop_cnt[k] == 0 && $urandom_range(99) < stb_pct) begin
        in_stb[k]  = 1'b1;
        in_data[k] = req_q[k][0];
      end else begin
        in_stb[k]  = 1'b0;
        in_data[k] = $urandom;
      end
      if (drop_cnt[k] > 0) drop_cnt[k]--;
    end
    output_tx_ack = ($urandom_range(99) < ack_pct);
    #1;
    s_ack     = in_ack;
    s_stb     = in_stb;
    for (int k = 0; k < 3; k++) s_data[k] = in_data[k];
    s_out_stb = output_tx_stb;
    s_out_tx  = output_tx;
    s_out_ack = output_tx_ack;
    s_grant   = grant;
    have_snap = 1'b1;
    @(posedge clk);
  endtask

  function automatic bit pending();
    return (req_q[0].size() + req_q[1].size() + req_q[2].size() + exp_q.size() != 0)
           || in_owner >= 0 || !have_snap || s_grant != 2'd3;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && pending()) begin
      step();
      n++;
    end
    step();
    check_eq("drain_done", n < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    in_stb = 3'b111;
    for (int k = 0; k < 3; k++) in_data[k] = $urandom;
    output_tx_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_ack", in_ack, 0);
    check_eq("rst_grant", grant, 3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_stb", output_tx_stb, 0);
    check_eq("rst_tx", output_tx, 0);
    rst           = 1'b0;
    in_stb        = 3'b000;
    output_tx_ack = 1'b0;
    model_clear();
    out_log.delete();
    grant_log.delete();
  endtask

  initial begin
    logic [31:0] exp34 [3];
    int          n;
    exp34 = '{32'h2, 32'hA, 32'hB};
    for (int k = 0; k < 3; k++) in_data[k] = '0;

    do_reset();

    // Single three-word packet from requester 1.
    stb_pct = 100;
    ack_pct = 100;
    req_q[1].push_back(32'h0000_0002);
    req_q[1].push_back(32'h0000_000A);
    req_q[1].push_back(32'h0000_000B);
    drain(100);
    check_eq("t34_count", out_log.size(), 3);
    for (int i = 0; i < out_log.size() && i < 3; i++) check_eq("t34_word", out_log[i], exp34[i]);
    check_eq("t34_grant", (grant_log.size() > 0) ? grant_log[0] : 9, 1);
    check_eq("t34_idle_grant", grant, 3);
    check_eq("t34_idle_busy", busy, 0);

    // Round-robin order with everyone offering header-only packets.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) req_q[k].push_back(32'h0);
    drain(200);
    check_eq("t35_count", out_log.size(), 6);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check_eq("t35_order", grant_log[i], i % 3);

    // Sink stalls mid-packet.
    out_log.delete();
    push_packet(0, 3);
    ack_pct = 0;
    repeat (14) step();
    ack_pct = 100;
    drain(100);
    check_eq("t36_count", out_log.size(), 4);

    // Owner drops stb mid-packet while another requester waits.
    out_log.delete();
    grant_log.delete();
    drop_en = 1'b1;
    push_packet(2, 3);
    n = 0;
    while (n < 20 && !(have_snap && s_grant == 2'd2)) begin
      step();
      n++;
    end
    check_eq("t37_granted", s_grant, 2);
    push_packet(0, 0);
    drain(200);
    drop_en = 1'b0;
    check_eq("t37_npkts", grant_log.size(), 2);
    for (int i = 0; i < grant_log.size() && i < 2; i++) check_eq("t37_order", grant_log[i], (i == 0) ? 2 : 0);
    check_eq("t37_count", out_log.size(), 5);

    // Reset while a word is pending in the output stage.
    do_reset();
    push_packet(1, 3);
    ack_pct = 0;
    n = 0;
    while (n < 20 && !(have_snap && s_out_stb && s_grant == 2'd1)) begin
      step();
      n++;
    end
    check_eq("t38_in_send", s_out_stb, 1);
    do_reset();
    ack_pct = 100;
    for (int k = 0; k < 3; k++) req_q[k].push_back(32'h0);
    drain(100);
    check_eq("t38_first_grant", (grant_log.size() > 0) ? grant_log[0] : 9, 0);
    check_eq("t38_count", out_log.size(), 3);

    // Maximum-length packet.
    out_log.delete();
    push_packet(0, 255);
    drain(700);
    check_eq("t39_count", out_log.size(), 256);
    check_eq("t39_idle", grant, 3);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      stb_pct = $urandom_range(50, 100);
      ack_pct = $urandom_range(30, 100);
      for (int p = 0; p < 10; p++) push_packet($urandom_range(0, 2), $urandom_range(0, 5));
      drain(2000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
